// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package rv32i_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [6:0]  HALT_OPCODE = 7'h7F;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr[6:0] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush overrides push/pop.
module fetch_fifo
  import rv32i_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count == CW'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  // Writing while full is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC owner, fetch buffer, redirect and halt handling.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = {DWIDTH{1'b0}},
  parameter int                BUF_DEPTH    = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  output logic [DWIDTH-1:0] Program_Count,
  input  logic [31:0]       Instruction,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_PC,
  output logic              Dec_Valid,
  input  logic              Dec_Ready,
  output logic [31:0]       Dec_Instr,
  output logic [DWIDTH-1:0] Dec_PC,
  output logic              Fetch_Halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       Perf_Fetch_Cnt,
  output logic [31:0]       Perf_Stall_Cnt,
`endif
  output logic              Fetch_Misaligned
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [DWIDTH-1:0] fetch_pc;
  logic [DWIDTH-1:0] pc_next;
  logic              misaligned;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign Program_Count    = fetch_pc;
  assign Fetch_Halted     = (state == HALTED);
  assign Fetch_Misaligned = misaligned;
  assign Dec_Valid        = !empty;
  assign Dec_Instr        = empty ? NOP_INSTR : head.instr;
  assign Dec_PC           = empty ? {DWIDTH{1'b0}} : DWIDTH'(head.pc);

  assign pop  = Dec_Valid && Dec_Ready;
  assign push = (state == RUN) && !Redirect_Valid && (!full || pop);

  assign push_entry.pc    = XLEN'(fetch_pc);
  assign push_entry.instr = Instruction;

  fetch_fifo #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (Clk_Core),
    .rst_n    (Rst_Core_N),
    .push     (push),
    .pop      (pop),
    .flush    (Redirect_Valid),
    .push_data(push_entry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  // Next state and next fetch address.
  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    case (state)
      RUN: begin
        if (Redirect_Valid) begin
          state_next = RUN;
        end else if (push && is_halt(Instruction)) begin
          state_next = HALTED;
        end else begin
          state_next = RUN;
        end
      end
      HALTED: begin
        if (Redirect_Valid) begin
          state_next = RUN;
        end else begin
          state_next = HALTED;
        end
      end
      default: state_next = RUN;
    endcase

    // A halting word is enqueued but the PC stays on it.
    if (Redirect_Valid) begin
      pc_next = {Redirect_PC[DWIDTH-1:2], 2'b00};
    end else if (push && !is_halt(Instruction)) begin
      pc_next = fetch_pc + DWIDTH'(4);
    end else begin
      pc_next = fetch_pc;
    end
  end

  // State, PC and misalignment pulse registers.
  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      state      <= RUN;
      fetch_pc   <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= pc_next;
      misaligned <= Redirect_Valid && (Redirect_PC[1:0] != 2'b00);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = (state == RUN) && !push && !Redirect_Valid;

  // Saturating performance counters.
  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      Perf_Fetch_Cnt <= 32'h0000_0000;
      Perf_Stall_Cnt <= 32'h0000_0000;
    end else begin
      if (push && (Perf_Fetch_Cnt != 32'hFFFF_FFFF)) begin
        Perf_Fetch_Cnt <= Perf_Fetch_Cnt + 32'd1;
      end
      if (stall && (Perf_Stall_Cnt != 32'hFFFF_FFFF)) begin
        Perf_Stall_Cnt <= Perf_Stall_Cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default build plus a wrap-around reset-vector instance).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redir;
  logic [31:0] redir_pc;
  logic        ready;
  logic        halt_en;

  logic [31:0] pc1, instr1, dinstr1, dpc1;
  logic        dvalid1, halted1, mis1;
  logic [31:0] pc2, instr2, dinstr2, dpc2;
  logic        dvalid2, halted2, mis2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  int checks;
  int fails;

  // Memory model: PC 0 holds addi a0,x0,12; PC 0xC holds the halt opcode when enabled.
  function automatic logic [31:0] mem_word(input logic [31:0] pc, input logic hen);
    if (pc == 32'h0000_0000) return 32'h00c0_0513;
    if (hen && pc == 32'h0000_000C) return 32'h0000_007f;
    return {pc[19:0], 12'h013};
  endfunction

  assign instr1 = mem_word(pc1, halt_en);
  assign instr2 = {pc2[19:0], 12'h013};

  fetch_unit u_dut (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Program_Count(pc1), .Instruction(instr1),
    .Redirect_Valid(redir), .Redirect_PC(redir_pc), .Dec_Valid(dvalid1), .Dec_Ready(ready),
    .Dec_Instr(dinstr1), .Dec_PC(dpc1), .Fetch_Halted(halted1),
`ifdef FETCH_PERF_CNT_EN
    .Perf_Fetch_Cnt(pf1), .Perf_Stall_Cnt(ps1),
`endif
    .Fetch_Misaligned(mis1)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_wrap (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Program_Count(pc2), .Instruction(instr2),
    .Redirect_Valid(1'b0), .Redirect_PC(32'h0000_0000), .Dec_Valid(dvalid2), .Dec_Ready(1'b1),
    .Dec_Instr(dinstr2), .Dec_PC(dpc2), .Fetch_Halted(halted2),
`ifdef FETCH_PERF_CNT_EN
    .Perf_Fetch_Cnt(pf2), .Perf_Stall_Cnt(ps2),
`endif
    .Fetch_Misaligned(mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rst_n    = 1'b0;
    redir    = 1'b0;
    redir_pc = 32'h0000_0000;
    ready    = 1'b1;
    halt_en  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_pc", pc1, 32'h0000_0000);
    check("rst_valid", {31'd0, dvalid1}, 32'd0);
    check("rst_instr", dinstr1, 32'h0000_0013);
    check("rst_dpc", dpc1, 32'h0000_0000);
    check("rst_halted", {31'd0, halted1}, 32'd0);
    check("rst_mis", {31'd0, mis1}, 32'd0);
    check("rst_pc_wrap", pc2, 32'hFFFF_FFF8);

    // Streaming from reset with decode always ready
    rst_n = 1'b1;
    check("t1_pc0", pc1, 32'h0000_0000);
    tick();
    check("t1_valid", {31'd0, dvalid1}, 32'd1);
    check("t1_dpc", dpc1, 32'h0000_0000);
    check("t1_dinstr", dinstr1, 32'h00c0_0513);
    check("t1_pc4", pc1, 32'h0000_0004);
    check("wrap_dpc0", dpc2, 32'hFFFF_FFF8);
    check("wrap_dinstr0", dinstr2, 32'hFFFF_8013);
    check("wrap_pc1", pc2, 32'hFFFF_FFFC);
    check("wrap_flags", {29'd0, dvalid2, halted2, mis2}, 32'h0000_0004);
    tick();
    check("t1_dpc4", dpc1, 32'h0000_0004);
    check("t1_pc8", pc1, 32'h0000_0008);
    check("wrap_dpc1", dpc2, 32'hFFFF_FFFC);
    check("wrap_pc2", pc2, 32'h0000_0000);
    tick();
    check("wrap_dpc2", dpc2, 32'h0000_0000);

    // Mid-operation reset, then back-pressure fills the buffer
    rst_n = 1'b0;
    tick();
    check("rst2_valid", {31'd0, dvalid1}, 32'd0);
    check("rst2_pc", pc1, 32'h0000_0000);
    rst_n = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_pc", pc1, 32'h0000_0008);
    check("bp_valid", {31'd0, dvalid1}, 32'd1);
    check("bp_head", dpc1, 32'h0000_0000);
    ready = 1'b1;
    tick();
    check("drain_1", dpc1, 32'h0000_0004);
    tick();
    check("drain_2", dpc1, 32'h0000_0008);
    check("drain_pc", pc1, 32'h0000_0010);

    // Redirect while full
    ready = 1'b0;
    tick();
    check("full_pc", pc1, 32'h0000_0010);
    redir    = 1'b1;
    redir_pc = 32'h0000_0030;
    tick();
    check("redir_valid", {31'd0, dvalid1}, 32'd0);
    check("redir_pc", pc1, 32'h0000_0030);
    redir = 1'b0;
    ready = 1'b1;
    tick();
    check("redir_dpc", dpc1, 32'h0000_0030);
    check("redir_dinstr", dinstr1, 32'h0003_0013);

    // Halt opcode at 0xC
    halt_en  = 1'b1;
    redir    = 1'b1;
    redir_pc = 32'h0000_0000;
    tick();
    redir = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("halt_flag", {31'd0, halted1}, 32'd1);
    check("halt_pc", pc1, 32'h0000_000C);
    check("halt_dpc", dpc1, 32'h0000_000C);
    check("halt_dinstr", dinstr1, 32'h0000_007f);
    tick();
    check("halt_drained", {31'd0, dvalid1}, 32'd0);
    check("halt_pc_hold", pc1, 32'h0000_000C);
    redir    = 1'b1;
    redir_pc = 32'h0000_0010;
    tick();
    check("resume_flag", {31'd0, halted1}, 32'd0);
    check("resume_pc", pc1, 32'h0000_0010);
    redir = 1'b0;
    tick();
    check("resume_dpc", dpc1, 32'h0000_0010);
    check("resume_pc_next", pc1, 32'h0000_0014);

    // Misaligned redirect target
    check("mis_idle", {31'd0, mis1}, 32'd0);
    redir    = 1'b1;
    redir_pc = 32'h0000_0022;
    tick();
    check("mis_pulse", {31'd0, mis1}, 32'd1);
    check("mis_pc", pc1, 32'h0000_0020);
    redir = 1'b0;
    tick();
    check("mis_clear", {31'd0, mis1}, 32'd0);
    check("mis_dpc", dpc1, 32'h0000_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
